wor_bus_arbiter: RTL and testbench

- Round-robin ownership arbiter for a shared wired-OR/wired-AND net that several sources would otherwise drive at the same time.
- Grants exactly one requester at a time and enforces a maximum hold time.
- Inserts a turnaround gap with no drivers between owners, so the shared net never sees overlapping drivers.
- Sits beside the net's driver instances; its grant vector gates each driver's enable.

---
 rtl/wor_bus_arb_pkg.sv | 7 +
 rtl/rr_picker.sv | 26 ++
 rtl/wor_bus_arbiter.sv | 65 ++++++
 tb/tb_wor_bus_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/wor_bus_arb_pkg.sv
// wor_bus_arb_pkg: shared state encoding and sizing helper for the wired-OR bus arbiter
package wor_bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin selection of the first request after the pointer, wrapping modulo N
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W:0] NW = (W + 1)'(N);
  logic [W-1:0] start, k;
  logic [N-1:0] rot;
  logic [W:0] sum;
  // rotate so the slot after the pointer sits at bit 0, priority-encode, then rotate back
  always_comb begin
    start = ptr == LAST ? '0 : ptr + 1'b1;
    rot = N'({req, req} >> start);
    k = '0;
    for (int i = N - 1; i >= 0; i--) k = rot[i] ? W'(i) : k;
    sum = {1'b0, start} + {1'b0, k};
    idx = sum >= NW ? W'(sum - NW) : W'(sum);
    found = |req;
  end
endmodule

// File: rtl/wor_bus_arbiter.sv
// wor_bus_arbiter: round-robin owner arbiter with hold limit and driver-free turnaround for a shared wired net
module wor_bus_arbiter
  import wor_bus_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            done_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        drv_en_o,
  output logic [idx_w(N_REQ)-1:0]     owner_o,
  output logic                        timeout_o,
  output logic                        busy_o
);
  localparam int IW = idx_w(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [2:0] TA = 3'(TURNAROUND);
  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);
  state_t state;
  logic [HW-1:0] hold;
  logic [2:0] tcnt;
  logic found, rel;
  logic [IW-1:0] win;
  rr_picker #(.N(N_REQ), .W(IW)) u_pick (.req(req_i), .ptr(owner_o), .found(found), .idx(win));
  assign rel = done_i[owner_o] | ~req_i[owner_o];
  assign drv_en_o = |grant_o;
  assign busy_o = state != IDLE;
  // a voluntary release wins over the hold limit, so timeout only fires when the owner still wanted the net
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_o <= '0;
      owner_o <= LAST;
      timeout_o <= 1'b0;
      hold <= '0;
      tcnt <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: if (found) begin
          grant_o <= {{(N_REQ - 1){1'b0}}, 1'b1} << win;
          owner_o <= win;
          state <= OWN;
          hold <= HW'(1);
        end
        OWN: if (rel || hold == HMAX) begin
          grant_o <= '0;
          state <= TURN;
          tcnt <= 3'd1;
          timeout_o <= ~rel;
        end else begin
          hold <= hold == HMAX ? hold : hold + 1'b1;
        end
        TURN: if (tcnt == TA) state <= IDLE;
              else tcnt <= tcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wor_bus_arbiter.sv
// tb_wor_bus_arbiter: directed vector bench for wor_bus_arbiter with N_REQ=4, MAX_HOLD=16, TURNAROUND=1
module tb_wor_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_i = '0, done_i = '0, grant_o;
  logic drv_en_o, timeout_o, busy_o;
  logic [1:0] owner_o;
  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [3:0] req, done, grant;
    logic busy, to;
    logic [1:0] owner;
  } vec_t;
  vec_t vecs[$];

  wor_bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURNAROUND(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .done_i(done_i), .grant_o(grant_o),
    .drv_en_o(drv_en_o), .owner_o(owner_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!$onehot0(grant_o) || drv_en_o !== (grant_o != 0)) begin
    miscompares++;
    $display("FAIL onehot/drv_en: grant=%b drv_en=%b", grant_o, drv_en_o);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(logic [3:0] r, logic [3:0] d);
    req_i = r;
    done_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic [3:0] r, logic [3:0] d, logic [3:0] g, logic b, logic t, logic [1:0] o);
    vecs.push_back('{r, d, g, b, t, o});
  endtask

  task automatic chk_all(string nm, logic [3:0] g, logic b, logic t, logic [1:0] o);
    chk({nm, " grant"}, 32'(grant_o), 32'(g));
    chk({nm, " busy"}, 32'(busy_o), 32'(b));
    chk({nm, " timeout"}, 32'(timeout_o), 32'(t));
    chk({nm, " owner"}, 32'(owner_o), 32'(o));
  endtask

  initial begin
    logic [1:0] alt[4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    // three grant cycles, done in the fourth, then one TURN->IDLE cycle
    foreach (alt[j]) begin
      for (int c = 0; c < 3; c++) add(4'b1010, 4'b0000, 4'b0001 << alt[j], 1'b1, 1'b0, alt[j]);
      add(4'b1010, 4'b0001 << alt[j], 4'b0000, 1'b1, 1'b0, alt[j]);
      add(4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, alt[j]);
    end
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 1'b0, 1'b0, 2'd3);
    chk("reset drv_en", 32'(drv_en_o), 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      step(4'b0000, 4'b0000);
      chk_all($sformatf("idle%0d", c), 4'b0000, 1'b0, 1'b0, 2'd3);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].done);
      chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].to, vecs[i].owner);
    end

    for (int c = 0; c < 16; c++) begin
      step(4'b0001, 4'b0000);
      chk_all($sformatf("hold%0d", c + 1), 4'b0001, 1'b1, 1'b0, 2'd0);
    end
    step(4'b0001, 4'b0000);
    chk_all("timeout", 4'b0000, 1'b1, 1'b1, 2'd0);
    step(4'b0001, 4'b0000);
    chk_all("post_timeout", 4'b0000, 1'b0, 1'b0, 2'd0);
    step(4'b0001, 4'b0000);
    chk_all("regrant", 4'b0001, 1'b1, 1'b0, 2'd0);

    step(4'b0001, 4'b0100);
    chk_all("foreign_done", 4'b0001, 1'b1, 1'b0, 2'd0);
    repeat (14) step(4'b0001, 4'b0000);
    chk_all("hold16", 4'b0001, 1'b1, 1'b0, 2'd0);
    step(4'b0001, 4'b0001);
    chk_all("done_at_limit", 4'b0000, 1'b1, 1'b0, 2'd0);
    step(4'b0000, 4'b0000);
    chk_all("done_at_limit_idle", 4'b0000, 1'b0, 1'b0, 2'd0);

    rst_n = 1'b0;
    step(4'b0000, 4'b0000);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      logic [1:0] o;
      o = 2'(j);
      step(4'b1111, 4'b0000);
      chk_all($sformatf("rr%0d", j), 4'b0001 << o, 1'b1, 1'b0, o);
      step(4'b1111 & ~(4'b0001 << o), 4'b0000);
      chk_all($sformatf("rr%0d_drop", j), 4'b0000, 1'b1, 1'b0, o);
      step(4'b1111, 4'b0000);
      chk_all($sformatf("rr%0d_gap", j), 4'b0000, 1'b0, 1'b0, o);
    end

    step(4'b0010, 4'b0000);
    chk_all("pre_reset_own", 4'b0010, 1'b1, 1'b0, 2'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 1'b0, 1'b0, 2'd3);
    chk("async_reset drv_en", 32'(drv_en_o), 32'd0);
    req_i = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 4'b0000);
    chk_all("after_reset", 4'b0100, 1'b1, 1'b0, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
